led_pattern_controller: RTL and testbench
=========================================

# led_pattern_controller

Board-level LED sequencer for the Tang Nano 9K examples. It debounces the raw `button1` input and steps a mode state machine on every clean press. It drives the 6-bit `led` bus with a per-mode pattern (off, all on, binary count, chase, blink), advanced by an internal step timer. It sits directly between the board's button pin and LED pins and replaces the direct button-to-LED wiring with a clocked controller.

## Interface
- `DEBOUNCE_CYCLES`, default 270_000: clocks the synchronized button must stay in a new level before it is accepted (10 ms at 27 MHz). Legal minimum is 2.
- `STEP_CYCLES`, default 13_500_000: clocks per pattern step (0.5 s at 27 MHz). Legal minimum is 2.
- `clk`, input, 1: system clock (27 MHz on board).
- `rst`, input, 1: asynchronous, active-high reset. One clock, `clk`; all flops reset asynchronously on `rst` high.
- `button1`, input, 1: raw board button, asynchronous to `clk`, active-low (0 = pressed).
- `led`, output, 6: board LEDs, active-low (0 = lit).

## Operation
- **Synchronizer.** Two flops on `button1`, reset value 1.
- **Debouncer.**
  - Stable level `db` resets to 1. Counter `dcnt` resets to 0.
  - While `sync2 != db`: if `dcnt == DEBOUNCE_CYCLES-1`, then `db <= sync2` and `dcnt <= 0`; otherwise `dcnt` increments.
  - While `sync2 == db`: `dcnt <= 0`, so any glitch shorter than `DEBOUNCE_CYCLES` is discarded.
- **Press event.** A 1-cycle registered pulse on the `db` 1→0 transition. Releases (0→1) generate nothing.
- **Mode FSM.** Encoding: OFF=0, ON=1, COUNT=2, CHASE=3, BLINK=4. Reset state is OFF. Each press advances OFF→ON→COUNT→CHASE→BLINK→OFF. Codes 5–7 are unreachable; if entered, the FSM goes to OFF on the next clock.
- **Step timer.**
  - `scnt` counts 0..`STEP_CYCLES`-1 and wraps.
  - The step pulse is asserted for the one cycle where `scnt == STEP_CYCLES-1`.
  - `scnt` resets to 0 and is forced to 0 on the cycle a press is processed.
- **Pattern register `pat[5:0]`** (1 = lit), reset 000000.
  - On mode entry, `pat` loads: OFF 000000, ON 111111, COUNT 000000, CHASE 000001, BLINK 000000.
  - On a step pulse:
    - COUNT: `pat <= pat + 1`, modulo 64 (63 wraps to 0).
    - CHASE: rotate left; 100000 becomes 000001.
    - BLINK: `pat <= ~pat`.
    - OFF and ON: hold.
- **Output.** `led = ~pat`, a pure inversion of a flop with no other logic. Reset value of `led` is 6'b111111 (all dark).
- **Simultaneous press and step pulse in the same cycle.** The press wins: mode advances, `pat` loads the entry value, and `scnt` clears. The step is dropped.
- **Button held indefinitely.** Produces exactly one press; no auto-repeat.
- **`rst` asserted mid-operation.** Immediately forces all flops to reset values. `led` goes to 111111 asynchronously. After `rst` deasserts, the block starts in OFF with all counters at 0.

## Timing
- **Press latency.** `button1` low is first sampled at edge N. `sync2` shows 0 at edge N+1. `db` falls at edge N+1+`DEBOUNCE_CYCLES`. The press pulse, mode and `pat` update at edge N+2+`DEBOUNCE_CYCLES`. `led` therefore changes `DEBOUNCE_CYCLES`+2 edges after first sample.
- **Step period.** Exactly `STEP_CYCLES` clocks between consecutive `pat` updates within a mode. The first step after a mode entry occurs `STEP_CYCLES` clocks after the entry edge.
- **Release.** A release must also be stable for `DEBOUNCE_CYCLES` before `db` returns to 1. A second press is not recognized until that has happened.
- **No combinational path from `button1` to `led`.**

## Test plan
Benches use `DEBOUNCE_CYCLES`=4 and `STEP_CYCLES`=8.
- **Reset.** Assert `rst` with `button1`=1, then deassert → `led`=111111, mode OFF. Run 100 clocks → `led` stays 111111.
- **Debounce.** Pulse `button1` low for 3 clocks, then high → no mode change. Then hold low for 20 clocks → `led`=000000 (mode ON) exactly 6 edges after first low sample.
- **COUNT wrap.** Press twice (release ≥6 clocks between presses) → COUNT. `led` takes ~1, ~2, … at 8-clock intervals. After 64 steps, `pat` wraps from 63 to 0 (`led` 000000 → 111111).
- **CHASE rotation.** Advance to CHASE → `pat` 000001. Then 000010, 000100, 001000, 010000, 100000, 000001 every 8 clocks.
- **BLINK and wrap to OFF.** In BLINK, `pat` toggles 000000/111111 every 8 clocks. One more press → OFF, `led`=111111 and held.
- **Press/step collision and mid-run reset.** In CHASE, time the press pulse to coincide with `scnt`=7 → mode BLINK, `pat`=000000, next toggle 8 clocks later. Assert `rst` asynchronously mid-step → `led`=111111 immediately, mode OFF.

Source files
------------

// File: rtl/led_pattern_controller.sv
// LED sequencer: debounces button1, steps a five-mode FSM on each clean press,
// and drives a per-mode 6-bit pattern (active-low LEDs) advanced by a step timer.
module led_pattern_controller #(
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int STEP_CYCLES     = 13_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button1,
    output logic [5:0] led
);

    localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SLAST = SW'(STEP_CYCLES - 1);

    typedef enum logic [2:0] {
        MODE_OFF   = 3'd0,
        MODE_ON    = 3'd1,
        MODE_COUNT = 3'd2,
        MODE_CHASE = 3'd3,
        MODE_BLINK = 3'd4
    } mode_t;

    mode_t         mode;
    mode_t         mode_next;
    logic [5:0]    pat;
    logic [5:0]    pat_next;
    logic [SW-1:0] scnt;
    logic [SW-1:0] scnt_next;
    logic [DW-1:0] dcnt;
    logic          sync1;
    logic          sync2;
    logic          db;
    logic          press;
    logic          step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= button1;
            sync2 <= sync1;
        end
    end

    // The press pulse is registered on the same edge db falls, so the mode
    // reacts on the following edge; rising edges (releases) never pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db    <= 1'b1;
            dcnt  <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 != db) begin
                if (dcnt == DLAST) begin
                    db    <= sync2;
                    dcnt  <= '0;
                    press <= db;
                end else begin
                    dcnt <= dcnt + DW'(1);
                end
            end else begin
                dcnt <= '0;
            end
        end
    end

    assign step = (scnt == SLAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= MODE_OFF;
            pat  <= '0;
            scnt <= '0;
        end else begin
            mode <= mode_next;
            pat  <= pat_next;
            scnt <= scnt_next;
        end
    end

    // A press takes priority over a coincident step: the step is simply lost.
    always_comb begin
        mode_next = mode;
        pat_next  = pat;
        scnt_next = step ? '0 : scnt + SW'(1);
        if (press) begin
            scnt_next = '0;
            case (mode)
                MODE_OFF: begin
                    mode_next = MODE_ON;
                    pat_next  = 6'b111111;
                end
                MODE_ON: begin
                    mode_next = MODE_COUNT;
                    pat_next  = 6'b000000;
                end
                MODE_COUNT: begin
                    mode_next = MODE_CHASE;
                    pat_next  = 6'b000001;
                end
                MODE_CHASE: begin
                    mode_next = MODE_BLINK;
                    pat_next  = 6'b000000;
                end
                default: begin
                    mode_next = MODE_OFF;
                    pat_next  = 6'b000000;
                end
            endcase
        end else begin
            case (mode)
                MODE_OFF, MODE_ON: begin
                    pat_next = pat;
                end
                MODE_COUNT: begin
                    if (step) pat_next = pat + 6'd1;
                end
                MODE_CHASE: begin
                    if (step) pat_next = {pat[4:0], pat[5]};
                end
                MODE_BLINK: begin
                    if (step) pat_next = ~pat;
                end
                default: begin
                    mode_next = MODE_OFF;
                    pat_next  = 6'b000000;
                end
            endcase
        end
    end

    assign led = ~pat;

endmodule

// File: tb/tb_led_pattern_controller.sv
// Directed bench for led_pattern_controller: expected LED values and the cycle
// they must appear on are queued when a stimulus is applied, then drained.
module tb_led_pattern_controller;

    logic       clk;
    logic       rst;
    logic       button1;
    logic [5:0] led;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [5:0] val;
        int         at;
        string      tag;
    } exp_t;

    exp_t sb[$];

    led_pattern_controller #(
        .DEBOUNCE_CYCLES(4),
        .STEP_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .button1(button1),
        .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic void push_exp(logic [5:0] val, int at, string tag);
        exp_t e;
        e.val = val;
        e.at  = at;
        e.tag = tag;
        sb.push_back(e);
    endfunction

    // Every wait is bounded; a missed sample point shows up as a cycle mismatch.
    task automatic check_output();
        exp_t e;
        int   guard;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            guard = 0;
            while (cyc < e.at && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
            compared++;
            assert (cyc == e.at && led === e.val) else begin
                mismatched++;
                $error("[TB] FAIL %s: led=%b at cycle %0d, required led=%b at cycle %0d",
                       e.tag, led, cyc, e.val, e.at);
            end
        end
    endtask

    task automatic press_button(output int entry);
        button1 = 1'b0;
        entry   = cyc + 7;
    endtask

    task automatic release_button();
        button1 = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int         entry;
        logic [5:0] v;

        rst     = 1'b1;
        button1 = 1'b1;
        repeat (3) @(negedge clk);
        push_exp(6'h3F, cyc, "reset held");
        check_output();
        rst = 1'b0;
        @(negedge clk);
        push_exp(6'h3F, cyc, "after reset");
        for (int i = 10; i <= 100; i += 10) push_exp(6'h3F, cyc + i, $sformatf("idle off +%0d", i));
        check_output();

        // Three low samples leave the debouncer one count short of accepting.
        button1 = 1'b0;
        repeat (3) @(negedge clk);
        button1 = 1'b1;
        push_exp(6'h3F, cyc + 10, "glitch ignored");
        check_output();

        press_button(entry);
        push_exp(6'h3F, entry - 1, "on not early");
        push_exp(6'h00, entry, "on entry");
        push_exp(6'h00, entry + 13, "held no repeat");
        check_output();
        release_button();

        press_button(entry);
        push_exp(6'h00, entry - 1, "count not early");
        push_exp(6'h3F, entry, "count entry");
        push_exp(6'h3F, entry + 7, "count step1 not early");
        for (int j = 1; j <= 64; j++) begin
            v = 6'(j);
            push_exp(~v, entry + 8 * j, $sformatf("count step %0d", j));
        end
        check_output();
        release_button();

        press_button(entry);
        push_exp(6'h3E, entry, "chase entry");
        for (int j = 1; j <= 7; j++) begin
            v = 6'b000001 << (j % 6);
            push_exp(~v, entry + 8 * j, $sformatf("chase step %0d", j));
        end
        check_output();
        release_button();

        press_button(entry);
        push_exp(6'h3F, entry, "blink entry");
        push_exp(6'h3F, entry + 7, "blink step1 not early");
        for (int j = 1; j <= 4; j++)
            push_exp((j % 2 == 1) ? 6'h00 : 6'h3F, entry + 8 * j, $sformatf("blink step %0d", j));
        check_output();
        release_button();

        press_button(entry);
        push_exp(6'h3F, entry, "off entry");
        push_exp(6'h3F, entry + 8, "off hold 8");
        push_exp(6'h3F, entry + 40, "off hold 40");
        check_output();
        release_button();

        press_button(entry);
        push_exp(6'h00, entry, "second on entry");
        check_output();
        release_button();
        press_button(entry);
        push_exp(6'h3F, entry, "second count entry");
        check_output();
        release_button();

        // Press pulse lands in the scnt==7 cycle before the second chase step.
        press_button(entry);
        push_exp(6'h3E, entry, "second chase entry");
        check_output();
        button1 = 1'b1;
        push_exp(6'h3D, entry + 8, "chase before collision");
        check_output();
        @(negedge clk);
        button1 = 1'b0;
        push_exp(6'h3D, entry + 15, "collision not early");
        push_exp(6'h3F, entry + 16, "collision blink entry");
        push_exp(6'h3F, entry + 23, "collision step dropped");
        push_exp(6'h00, entry + 24, "blink after collision");
        check_output();
        button1 = 1'b1;

        #2 rst = 1'b1;
        #1;
        compared++;
        assert (led === 6'h3F) else begin
            mismatched++;
            $error("[TB] FAIL async reset: led=%b, required %b", led, 6'h3F);
        end
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        push_exp(6'h3F, cyc + 20, "off after reset");
        check_output();
        press_button(entry);
        push_exp(6'h3F, entry - 1, "post reset not early");
        push_exp(6'h00, entry, "post reset on entry");
        check_output();
        release_button();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
